// File: rtl/bus_capture_8_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_capture_8_if
// Brief    : Write-capture and drain bus for the 8-slot capture block.
// Revision : 1.0
// ============================================================================
interface bus_capture_8_if;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] out0;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] out3;
    logic [31:0] out4;
    logic [31:0] out5;
    logic [31:0] out6;
    logic [31:0] out7;
    logic [7:0]  valid;
    logic        rd_valid;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic        overrun;

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_ready,
        output wr_ack, out0, out1, out2, out3, out4, out5, out6, out7,
               valid, rd_valid, rd_sel, rd_data, overrun
    );

    modport master (
        output wr_en, wr_sel, wr_data, rd_ready,
        input  wr_ack, out0, out1, out2, out3, out4, out5, out6, out7,
               valid, rd_valid, rd_sel, rd_data, overrun
    );
endinterface
`default_nettype wire

// File: rtl/bus_capture_8.sv
`default_nettype none
// ============================================================================
// Module   : bus_capture_8
// Brief    : Captures bus words into 8 slots and drains them round-robin.
// Revision : 1.0
// ============================================================================
module bus_capture_8 (
    input  wire              clock,
    input  wire              reset,
    bus_capture_8_if.slave   bus
);
    logic [31:0] r_slot [8];
    logic [7:0]  r_valid;
    logic [2:0]  r_ptr;
    logic        r_wr_ack;
    logic        r_overrun;

    logic [2:0]  w_rd_sel;
    logic        w_rd_valid;
    logic        w_drain;
    logic        w_same_slot_drain;

    // Scan from the highest offset down so the nearest valid slot to ptr wins.
    always_comb begin
        w_rd_sel = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (r_valid[r_ptr + 3'(k)]) begin
                w_rd_sel = r_ptr + 3'(k);
            end
        end
    end

    assign w_rd_valid        = |r_valid;
    assign w_drain           = w_rd_valid & bus.rd_ready;
    assign w_same_slot_drain = w_drain & (w_rd_sel == bus.wr_sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 32'd0;
            end
            r_valid   <= 8'h00;
            r_ptr     <= 3'd0;
            r_wr_ack  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_ack <= bus.wr_en;
            if (w_drain) begin
                r_valid[w_rd_sel] <= 1'b0;
                r_ptr             <= w_rd_sel + 3'd1;
            end
            // A write after the drain clear keeps the slot valid on a same-slot collision.
            if (bus.wr_en) begin
                r_slot[bus.wr_sel]  <= bus.wr_data;
                r_valid[bus.wr_sel] <= 1'b1;
                if (r_valid[bus.wr_sel] && !w_same_slot_drain) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_ack   = r_wr_ack;
    assign bus.overrun  = r_overrun;
    assign bus.valid    = r_valid;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_sel   = w_rd_sel;
    assign bus.rd_data  = r_slot[w_rd_sel];
    assign bus.out0     = r_slot[0];
    assign bus.out1     = r_slot[1];
    assign bus.out2     = r_slot[2];
    assign bus.out3     = r_slot[3];
    assign bus.out4     = r_slot[4];
    assign bus.out5     = r_slot[5];
    assign bus.out6     = r_slot[6];
    assign bus.out7     = r_slot[7];
endmodule
`default_nettype wire

// File: doc/bus_capture_8.md
# bus_capture_8

Write-side counterpart of the 8-way 32-bit shared-bus read select: captures a word from the shared bus into one of eight 32-bit slots chosen by a 3-bit select, tracks per-slot valid flags, and drains pending slots in round-robin order over a valid/ready handshake. It sits on the write end of the datapath bus, between the bus driver and consumers such as the game-state or sprite units. All eight slots also stay visible as parallel register outputs.

## Interface
- No parameters: slot count fixed at 8, word width fixed at 32.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is high.
- wr_en  in  1  capture request for this cycle.
- wr_sel  in  3  destination slot index, 0..7.
- wr_data  in  32  word on the shared bus.
- wr_ack  out  1  registered; high for exactly one cycle after each accepted write.
- out0..out7  out  32 each  current contents of slots 0..7.
- valid  out  8  bit i high means slot i holds undrained data.
- rd_valid  out  1  at least one slot is valid.
- rd_sel  out  3  slot offered for drain.
- rd_data  out  32  contents of slot rd_sel.
- rd_ready  in  1  consumer accepts the offered slot.
- overrun  out  1  sticky; set when a valid, undrained slot is overwritten.

## Operation
- Reset: all slots = 0, valid = 8'h00, round-robin pointer = 0, wr_ack = 0, overrun = 0. Reset overrides any wr_en or rd_ready in the same cycle.
- Write: when wr_en=1 on a rising edge:
  - slot[wr_sel] <= wr_data.
  - valid[wr_sel] <= 1.
  - wr_ack <= 1 on the next cycle.
- Writes are never refused.
- wr_ack <= 0 on any edge where wr_en=0.
- Drain selection is combinational from registered state:
  - rd_valid = |valid.
  - rd_sel = first index i with valid[i]=1, scanning ptr, ptr+1, ... with mod-8 wrap.
  - rd_data = slot[rd_sel].
- When rd_valid=0: rd_sel = ptr and rd_data = slot[ptr].
- Drain handshake: on an edge with rd_valid && rd_ready:
  - valid[rd_sel] <= 0.
  - ptr <= rd_sel + 1 (3-bit wrap, so 7 -> 0).
  - Slot data is not cleared.
- rd_ready with rd_valid=0 has no effect, and ptr is unchanged.
- Overrun: a write to slot s sets overrun when valid[s]=1 and s is not being drained on the same edge. overrun clears only on reset.
- Simultaneous write and drain of the same slot:
  - The old data is consumed.
  - The new data is stored and valid[s] stays 1.
  - No overrun.
  - ptr still advances to s+1.
- Simultaneous write to slot a and drain of a different slot b: both take effect independently.

## Timing
- Write to visibility: 1 cycle. Data written at edge N appears on outN/valid/rd_* after edge N, i.e. it is combinationally usable in cycle N+1.
- wr_ack is high during cycle N+1 only, for the write sampled at edge N. Back-to-back writes hold wr_ack high continuously.
- Drain throughput: one slot per cycle while rd_ready=1 and slots remain.
- rd_valid, rd_sel and rd_data depend only on registered state, with no combinational path from rd_ready. They may change only after an edge.
- Reset asserted mid-drain or mid-write: all outputs return to reset values after that edge. The pending transfer is discarded.

## Test plan
- Reset check: assert reset 2 cycles with wr_en=1, wr_sel=3, wr_data=32'hDEADBEEF. Required afterwards: valid=0, out3=0, wr_ack=0, overrun=0, rd_valid=0, rd_sel=0.
- Single capture/drain:
  - Write 32'h12345678 to slot 5. Next cycle: out5=32'h12345678, valid=8'h20, wr_ack=1, rd_sel=5.
  - Assert rd_ready 1 cycle. Next cycle: valid=0, rd_valid=0, rd_sel=6.
- Round-robin wrap:
  - Fill slots 1, 6, 7 (data 1, 6, 7), then drain 1 so ptr=2.
  - Write slot 0 (data 32'hA0), then hold rd_ready.
  - Required drain order of rd_data: 6, 7, 32'hA0. rd_valid then 0.
- Overrun: write slot 2 = 32'h11, then slot 2 = 32'h22 with no drain. Required: overrun=1, out2=32'h22, valid[2]=1. Overrun stays 1 after draining.
- Same-slot write+drain: slot 4 valid with 32'h44. On one edge assert wr_en (sel 4, data 32'h55) and rd_ready with rd_sel=4. Required: out4=32'h55, valid[4]=1, overrun=0.
- Back-to-back: writes on 8 consecutive cycles to slots 0..7 with data equal to the index. Required: wr_ack high for 8 consecutive cycles, valid=8'hFF, then 8 drains return 0..7 in order.
